// File: rtl/varredura_servo.sv
// Triangular position sweep for the servo PWM stage: posicao walks POS_MIN..POS_MAX..POS_MIN,
// stepped by an internal timer (auto) or by rising edges of passo (manual).
module varredura_servo #(
    parameter int INTERVALO = 25_000_000,
    parameter int POS_MIN   = 0,
    parameter int POS_MAX   = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       modo,
    input  logic       passo,
    output logic [2:0] posicao,
    output logic       sentido,
    output logic       fim_varredura,
    output logic [1:0] db_estado
);

    localparam int TW = (INTERVALO < 1) ? 1 : $clog2(INTERVALO + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(INTERVALO - 1);
    localparam logic [2:0] PMIN = 3'(POS_MIN);
    localparam logic [2:0] PMAX = 3'(POS_MAX);

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        ESPERA   = 2'b01,
        ATUALIZA = 2'b10
    } estado_t;

    estado_t       state;
    logic [TW-1:0] timer;
    logic          passo_d;
    logic          passo_sub;
    logic [2:0]    pos_next;

    assign passo_sub = passo & ~passo_d;
    assign db_estado = state;

    // The direction flag flips exactly when a bound is reached, so the step never wraps.
    always_comb begin
        pos_next = posicao;
        if (sentido) pos_next = posicao + 3'd1;
        else         pos_next = posicao - 3'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= PARADO;
            posicao       <= PMIN;
            sentido       <= 1'b1;
            fim_varredura <= 1'b0;
            timer         <= '0;
            passo_d       <= 1'b0;
        end else begin
            passo_d       <= passo;
            fim_varredura <= 1'b0;
            case (state)
                PARADO: begin
                    timer <= '0;
                    if (ligar) state <= ESPERA;
                end
                ESPERA: begin
                    if (!ligar) begin
                        state <= PARADO;
                        timer <= '0;
                    end else if (modo) begin
                        // Manual mode keeps the timer parked so a return to auto restarts a full interval.
                        timer <= '0;
                        if (passo_sub) state <= ATUALIZA;
                    end else if (timer == TIMER_LAST) begin
                        state <= ATUALIZA;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ATUALIZA: begin
                    timer   <= '0;
                    state   <= ligar ? ESPERA : PARADO;
                    posicao <= pos_next;
                    if (sentido && (pos_next == PMAX)) begin
                        sentido       <= 1'b0;
                        fim_varredura <= 1'b1;
                    end else if (!sentido && (pos_next == PMIN)) begin
                        sentido       <= 1'b1;
                        fim_varredura <= 1'b1;
                    end
                end
                default: begin
                    state <= PARADO;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_varredura_servo.sv
// Directed bench for varredura_servo: auto sweep, pause/resume, manual stepping,
// reset during an update, and a fast-interval instance.
module tb_varredura_servo;

    logic       clock;
    logic       reset;
    logic       ligar, modo, passo;
    logic [2:0] posicao;
    logic       sentido, fim_varredura;
    logic [1:0] db_estado;

    logic       ligar1, modo1, passo1;
    logic [2:0] posicao1;
    logic       sentido1, fim1;
    logic [1:0] db_estado1;

    int tests_run = 0;
    int tests_failed = 0;

    // {posicao, sentido, fim_varredura}
    logic [4:0] exp_q[$];
    logic [4:0] exp_e;
    logic [2:0] prev_pos;

    varredura_servo #(.INTERVALO(4), .POS_MIN(0), .POS_MAX(7)) dut (
        .clock(clock), .reset(reset), .ligar(ligar), .modo(modo), .passo(passo),
        .posicao(posicao), .sentido(sentido), .fim_varredura(fim_varredura),
        .db_estado(db_estado)
    );

    varredura_servo #(.INTERVALO(1), .POS_MIN(0), .POS_MAX(7)) dut1 (
        .clock(clock), .reset(reset), .ligar(ligar1), .modo(modo1), .passo(passo1),
        .posicao(posicao1), .sentido(sentido1), .fim_varredura(fim1),
        .db_estado(db_estado1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_entry(input string tag, input logic [4:0] e,
                               input logic [2:0] p, input logic s, input logic f);
        check({tag, ".posicao"}, 8'(p), 8'(e[4:2]));
        check({tag, ".sentido"}, 8'(s), 8'(e[1]));
        check({tag, ".fim"},     8'(f), 8'(e[0]));
    endtask

    task automatic pulse_passo();
        passo = 1'b1;
        wait_neg(1);
        passo = 1'b0;
        wait_neg(1);
    endtask

    initial begin
        reset = 1'b1; ligar = 1'b0; modo = 1'b0; passo = 1'b0;
        ligar1 = 1'b0; modo1 = 1'b0; passo1 = 1'b0;

        // Reset and idle
        wait_neg(2);
        reset = 1'b0;
        check("reset.posicao", 8'(posicao), 8'd0);
        check("reset.sentido", 8'(sentido), 8'd1);
        check("reset.fim", 8'(fim_varredura), 8'd0);
        check("reset.estado", 8'(db_estado), 8'd0);
        wait_neg(20);
        check("idle.posicao", 8'(posicao), 8'd0);
        check("idle.estado", 8'(db_estado), 8'd0);

        // Auto sweep 0..7..0 then up to 3
        for (int v = 1; v <= 7; v++) exp_q.push_back({3'(v), (v == 7) ? 1'b0 : 1'b1, (v == 7) ? 1'b1 : 1'b0});
        for (int v = 6; v >= 0; v--) exp_q.push_back({3'(v), (v == 0) ? 1'b1 : 1'b0, (v == 0) ? 1'b1 : 1'b0});
        for (int v = 1; v <= 3; v++) exp_q.push_back({3'(v), 1'b1, 1'b0});
        ligar = 1'b1;
        prev_pos = 3'd0;
        for (int i = 0; exp_q.size() > 0; i++) begin
            wait_neg((i == 0) ? 5 : 4);
            check("auto.hold", 8'(posicao), 8'(prev_pos));
            check("auto.hold_fim", 8'(fim_varredura), 8'd0);
            if (i == 0) check("auto.first_estado", 8'(db_estado), 8'd2);
            wait_neg(1);
            exp_e = exp_q.pop_front();
            check_entry("auto.step", exp_e, posicao, sentido, fim_varredura);
            prev_pos = exp_e[4:2];
        end

        // Pause at 3 ascending, then resume
        ligar = 1'b0;
        wait_neg(1);
        check("pause.estado", 8'(db_estado), 8'd0);
        wait_neg(10);
        check("pause.posicao", 8'(posicao), 8'd3);
        check("pause.sentido", 8'(sentido), 8'd1);
        ligar = 1'b1;
        wait_neg(5);
        check("resume.hold", 8'(posicao), 8'd3);
        wait_neg(1);
        check("resume.posicao", 8'(posicao), 8'd4);

        // Manual: passo held high gives one step
        modo = 1'b1;
        passo = 1'b1;
        wait_neg(10);
        check("held.posicao", 8'(posicao), 8'd5);
        check("held.estado", 8'(db_estado), 8'd1);
        passo = 1'b0;
        wait_neg(2);

        // Three pulses: 6, 7 (turn), 6
        exp_q.push_back({3'd6, 1'b1, 1'b0});
        exp_q.push_back({3'd7, 1'b0, 1'b1});
        exp_q.push_back({3'd6, 1'b0, 1'b0});
        while (exp_q.size() > 0) begin
            pulse_passo();
            exp_e = exp_q.pop_front();
            check_entry("manual.step", exp_e, posicao, sentido, fim_varredura);
            wait_neg(2);
        end
        check("manual.settled", 8'(posicao), 8'd6);

        // Walk down to 0 and back up to 6 ascending
        for (int v = 5; v >= 0; v--) exp_q.push_back({3'(v), (v == 0) ? 1'b1 : 1'b0, (v == 0) ? 1'b1 : 1'b0});
        for (int v = 1; v <= 6; v++) exp_q.push_back({3'(v), 1'b1, 1'b0});
        while (exp_q.size() > 0) begin
            pulse_passo();
            exp_e = exp_q.pop_front();
            check_entry("walk.step", exp_e, posicao, sentido, fim_varredura);
            wait_neg(1);
        end

        // Reset while in ATUALIZA: the pending step to 7 is dropped
        passo = 1'b1;
        wait_neg(1);
        check("pre_reset.estado", 8'(db_estado), 8'd2);
        reset = 1'b1;
        passo = 1'b0;
        wait_neg(1);
        reset = 1'b0;
        check("midreset.posicao", 8'(posicao), 8'd0);
        check("midreset.sentido", 8'(sentido), 8'd1);
        check("midreset.fim", 8'(fim_varredura), 8'd0);
        check("midreset.estado", 8'(db_estado), 8'd0);
        ligar = 1'b0;
        modo = 1'b0;

        // INTERVALO=1 instance: a change every 2 clocks, first after 3
        check("fast.reset_posicao", 8'(posicao1), 8'd0);
        for (int v = 1; v <= 7; v++) exp_q.push_back({3'(v), (v == 7) ? 1'b0 : 1'b1, (v == 7) ? 1'b1 : 1'b0});
        for (int v = 6; v >= 0; v--) exp_q.push_back({3'(v), (v == 0) ? 1'b1 : 1'b0, (v == 0) ? 1'b1 : 1'b0});
        ligar1 = 1'b1;
        prev_pos = 3'd0;
        for (int i = 0; exp_q.size() > 0; i++) begin
            wait_neg((i == 0) ? 2 : 1);
            check("fast.hold", 8'(posicao1), 8'(prev_pos));
            wait_neg(1);
            exp_e = exp_q.pop_front();
            check_entry("fast.step", exp_e, posicao1, sentido1, fim1);
            prev_pos = exp_e[4:2];
        end
        ligar1 = 1'b0;
        wait_neg(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
